// File: rtl/cpu_sequencer_pkg.sv
// Shared encodings for the d16 instruction sequencer: one-hot state vector
// positions, control width and parameter defaults.
package cpu_sequencer_pkg;

    localparam int CONTROL_BIT_MAX = 9;

    localparam int DEF_MEM_TIMEOUT         = 64;
    localparam int DEF_BRANCH_DELAY_CYCLES = 1;

    // One bit per state; IRQ keeps its slot even when interrupts are not built
    typedef enum logic [CONTROL_BIT_MAX:0] {
        STATE_FETCH        = 10'h001,
        STATE_DECODE       = 10'h002,
        STATE_REG_READ     = 10'h004,
        STATE_ALU          = 10'h008,
        STATE_MEM          = 10'h010,
        STATE_REG_WR       = 10'h020,
        STATE_PC_DELAY     = 10'h040,
        STATE_BRANCH_DELAY = 10'h080,
        STATE_IRQ          = 10'h100,
        STATE_FAULT        = 10'h200
    } state_t;

endpackage

// File: rtl/cpu_sequencer_wait_timer.sv
// seq_wait_timer: counts consecutive memory-wait cycles and flags the
// MEM_TIMEOUT-th one. Ports: clk, rst, clear, count in; timeout out.
// MEM_TIMEOUT=0 builds a constant-0 stub.
module seq_wait_timer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic timeout
);

    generate
        if (MEM_TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = clk ^ rst ^ clear ^ count;
            assign timeout   = 1'b0;
        end else begin : g_on
            localparam int W = $clog2(MEM_TIMEOUT + 1);
            logic [W-1:0] cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clear) begin
                    cnt <= '0;
                end else if (count) begin
                    cnt <= cnt + W'(1);
                end
            end

            // Fires during the wait cycle that would be the MEM_TIMEOUT-th
            assign timeout = count && (cnt == W'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: one-hot instruction sequencer with memory-wait timeout,
// branch-delay states and optional interrupt entry (macro CPU_SEQ_IRQ_EN).
// Ports: clk, rst (sync, high), en, en_mem, mem_wait, should_branch,
// irq_req, fault_clr in; control_o[9:0], irq_ack, fault_o, retire_o out.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int MEM_TIMEOUT         = DEF_MEM_TIMEOUT,
    parameter int BRANCH_DELAY_CYCLES = DEF_BRANCH_DELAY_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     en_mem,
    input  logic                     mem_wait,
    input  logic                     should_branch,
    input  logic                     irq_req,
    input  logic                     fault_clr,
    output logic [CONTROL_BIT_MAX:0] control_o,
    output logic                     irq_ack,
    output logic                     fault_o,
    output logic                     retire_o
);

`ifdef CPU_SEQ_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    localparam logic [2:0] BD_LOAD = 3'(BRANCH_DELAY_CYCLES - 1);

    state_t     state;
    logic [2:0] dcnt;
    logic       wait_st;
    logic       wait_cnt;
    logic       wait_clr;
    logic       timeout;
    state_t     boundary;

    assign wait_st  = (state == STATE_FETCH) || (state == STATE_MEM);
    assign wait_cnt = en && mem_wait && wait_st;
    // Any advancing cycle that is not a wait cycle restarts the count,
    // which also covers entry into FETCH or MEM
    assign wait_clr = en && !(mem_wait && wait_st);

    assign boundary = (IRQ_ON && irq_req) ? STATE_IRQ : STATE_FETCH;

    seq_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (wait_clr),
        .count  (wait_cnt),
        .timeout(timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STATE_FETCH;
            dcnt  <= '0;
        end else if (en) begin
            case (state)
                STATE_FETCH: begin
                    if (!mem_wait) begin
                        state <= STATE_DECODE;
                    end else if (timeout) begin
                        state <= STATE_FAULT;
                    end
                end
                STATE_DECODE:   state <= STATE_REG_READ;
                STATE_REG_READ: state <= STATE_ALU;
                STATE_ALU: begin
                    state <= en_mem ? STATE_MEM : STATE_REG_WR;
                end
                STATE_MEM: begin
                    if (!mem_wait) begin
                        state <= STATE_REG_WR;
                    end else if (timeout) begin
                        state <= STATE_FAULT;
                    end
                end
                STATE_REG_WR: begin
                    state <= should_branch ? STATE_PC_DELAY : boundary;
                end
                STATE_PC_DELAY: begin
                    state <= STATE_BRANCH_DELAY;
                    dcnt  <= BD_LOAD;
                end
                STATE_BRANCH_DELAY: begin
                    if (dcnt == 3'd0) begin
                        state <= boundary;
                    end else begin
                        dcnt <= dcnt - 3'd1;
                    end
                end
                STATE_IRQ: state <= STATE_FETCH;
                STATE_FAULT: begin
                    if (fault_clr) begin
                        state <= STATE_FETCH;
                    end
                end
                default: state <= STATE_FETCH;
            endcase
        end
    end

    assign control_o = state;
    assign irq_ack   = IRQ_ON && (state == STATE_IRQ);
    assign fault_o   = (state == STATE_FAULT);
    assign retire_o  = en && (state == STATE_REG_WR);

endmodule
